dispatch_scoreboard: RTL and testbench

- Parametrised successor of the register-read/dispatch stage, sitting between decode and the calculation units.
- Owns the architectural register file with WB_PORTS write ports and a per-register busy scoreboard.
- Adds RAW/WAW hazard stalling and same-cycle writeback forwarding, then queues issued instructions in a QDEPTH-entry output queue with valid/ready handshakes on both sides.
- Decode fields other than register addresses travel as an opaque payload.

---
 rtl/dispatch_scoreboard_pkg.sv | 24 ++
 rtl/dispatch_scoreboard_regfile.sv | 57 +++++
 rtl/dispatch_scoreboard.sv | 208 ++++++++++++++++++++
 tb/tb_dispatch_scoreboard.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_scoreboard_pkg.sv
// Shared definitions for the dispatch/scoreboard stage: default geometry,
// the writeback port record and a small pointer helper for the output queue.
package dispatch_scoreboard_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int NREG_DEF      = 32;
    localparam int WB_PORTS_DEF  = 2;
    localparam int QDEPTH_DEF    = 2;
    localparam int PAYLOAD_W_DEF = 96;
    localparam int REG_AD_W      = $clog2(NREG_DEF);

    // One writeback port at the default geometry.
    typedef struct packed {
        logic                v;
        logic [REG_AD_W-1:0] ad;
        logic [XLEN_DEF-1:0] data;
    } wb_port_t;

    // Advance a circular pointer, wrapping back to zero after depth-1.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr + 1 >= depth) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/dispatch_scoreboard_regfile.sv
// Multi-write-port architectural register file. Register 0 is hardwired to
// zero. When several ports write the same register in one cycle the
// highest-index port wins, both for the stored value and for the forwarded
// value seen by the read ports in that same cycle.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int WB_PORTS = 2,
    parameter int RD_PORTS = 2,
    parameter int AW       = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WB_PORTS-1:0] wb_v,
    input  logic [AW-1:0]       wb_ad   [WB_PORTS],
    input  logic [XLEN-1:0]     wb_data [WB_PORTS],
    input  logic [AW-1:0]       ra      [RD_PORTS],
    output logic [XLEN-1:0]     rdata   [RD_PORTS]
);

    logic [XLEN-1:0] regs_reg [NREG];

    // Apply writebacks in ascending port order so the last (highest) port's value sticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_v[p] && (wb_ad[p] != '0)) begin
                    regs_reg[wb_ad[p]] <= wb_data[p];
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < RD_PORTS; gi++) begin : g_rd
            logic [XLEN-1:0] port_val;

            // Regfile read overridden by any same-cycle writeback, highest port last.
            always_comb begin
                port_val = (ra[gi] == '0) ? '0 : regs_reg[ra[gi]];
                for (int p = 0; p < WB_PORTS; p++) begin
                    if (wb_v[p] && (wb_ad[p] == ra[gi]) && (ra[gi] != '0)) begin
                        port_val = wb_data[p];
                    end
                end
            end

            assign rdata[gi] = port_val;
        end
    endgenerate

endmodule

// File: rtl/dispatch_scoreboard.sv
// Register-read / dispatch stage: reads operands (with writeback forwarding),
// stalls on RAW/WAW hazards via a per-register busy scoreboard, and queues
// issued instructions in a small valid/ready output FIFO.
module dispatch_scoreboard
    import dispatch_scoreboard_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int NREG      = NREG_DEF,
    parameter int WB_PORTS  = WB_PORTS_DEF,
    parameter int QDEPTH    = QDEPTH_DEF,
    parameter int PAYLOAD_W = PAYLOAD_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_v,
    output logic                         in_ready,
    input  logic [$clog2(NREG)-1:0]      rs1_ad,
    input  logic                         rs1_use,
    input  logic [$clog2(NREG)-1:0]      rs2_ad,
    input  logic                         rs2_use,
    input  logic [$clog2(NREG)-1:0]      rd_ad,
    input  logic                         rd_use,
    input  logic [PAYLOAD_W-1:0]         payload_i,
    input  logic [WB_PORTS-1:0]          wb_v,
    input  logic [WB_PORTS*$clog2(NREG)-1:0] wb_ad,
    input  logic [WB_PORTS*XLEN-1:0]     wb_data,
    input  logic                         flush,
    output logic                         out_v,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              rs1_o,
    output logic [XLEN-1:0]              rs2_o,
    output logic [$clog2(NREG)-1:0]      rd_o,
    output logic                         rd_v_o,
    output logic [PAYLOAD_W-1:0]         payload_o,
    output logic [31:0]                  stall_cnt
);

    localparam int AW    = $clog2(NREG);
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);

    // Writeback port record sized to this instance's parameters.
    typedef struct packed {
        logic            v;
        logic [AW-1:0]   ad;
        logic [XLEN-1:0] data;
    } wb_lane_t;

    typedef struct packed {
        logic [XLEN-1:0]      rs1;
        logic [XLEN-1:0]      rs2;
        logic [AW-1:0]        rd;
        logic                 rd_v;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    wb_lane_t            wb_lane    [WB_PORTS];
    logic [AW-1:0]       rf_wb_ad   [WB_PORTS];
    logic [XLEN-1:0]     rf_wb_data [WB_PORTS];
    logic [WB_PORTS-1:0] rf_wb_v;
    logic [WB_PORTS-1:0] rs1_hit;
    logic [WB_PORTS-1:0] rs2_hit;
    logic [WB_PORTS-1:0] rd_hit;

    genvar gi;
    generate
        for (gi = 0; gi < WB_PORTS; gi++) begin : g_wb
            assign wb_lane[gi]    = {wb_v[gi], wb_ad[gi*AW +: AW], wb_data[gi*XLEN +: XLEN]};
            assign rf_wb_v[gi]    = wb_lane[gi].v;
            assign rf_wb_ad[gi]   = wb_lane[gi].ad;
            assign rf_wb_data[gi] = wb_lane[gi].data;
            assign rs1_hit[gi]    = wb_lane[gi].v && (wb_lane[gi].ad == rs1_ad);
            assign rs2_hit[gi]    = wb_lane[gi].v && (wb_lane[gi].ad == rs2_ad);
            assign rd_hit[gi]     = wb_lane[gi].v && (wb_lane[gi].ad == rd_ad);
        end
    endgenerate

    logic [AW-1:0]   rf_ra    [2];
    logic [XLEN-1:0] rf_rdata [2];

    assign rf_ra[0] = rs1_ad;
    assign rf_ra[1] = rs2_ad;

    regfile_mp #(
        .XLEN    (XLEN),
        .NREG    (NREG),
        .WB_PORTS(WB_PORTS),
        .RD_PORTS(2),
        .AW      (AW)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .wb_v   (rf_wb_v),
        .wb_ad  (rf_wb_ad),
        .wb_data(rf_wb_data),
        .ra     (rf_ra),
        .rdata  (rf_rdata)
    );

    // Scoreboard and queue state.
    logic [NREG-1:0]  busy_reg;
    logic [NREG-1:0]  busy_next;
    entry_t           queue_mem [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [31:0]      stall_cnt_reg;

    logic   rs1_ok;
    logic   rs2_ok;
    logic   rd_ok;
    logic   full;
    logic   push;
    logic   pop;
    entry_t entry_in;

    // A written-this-cycle register counts as ready: the value is forwarded and
    // the busy bit is cleared in the same edge.
    assign rs1_ok = !rs1_use || (rs1_ad == '0) || !busy_reg[rs1_ad] || (|rs1_hit);
    assign rs2_ok = !rs2_use || (rs2_ad == '0) || !busy_reg[rs2_ad] || (|rs2_hit);
    assign rd_ok  = !rd_use  || (rd_ad  == '0) || !busy_reg[rd_ad]  || (|rd_hit);
    assign full   = (count_reg == CNT_W'(QDEPTH));
    assign out_v  = (count_reg != '0);
    assign pop    = out_v && out_ready;

    assign in_ready = !flush && rs1_ok && rs2_ok && rd_ok && (!full || pop);
    assign push     = in_v && in_ready;

    assign entry_in.rs1     = rs1_use ? rf_rdata[0] : '0;
    assign entry_in.rs2     = rs2_use ? rf_rdata[1] : '0;
    assign entry_in.rd      = rd_ad;
    assign entry_in.rd_v    = rd_use && (rd_ad != '0);
    assign entry_in.payload = payload_i;

    // Busy vector update: clears from writebacks first, then the issuing
    // destination is set so a same-cycle set beats a clear.
    always_comb begin
        busy_next = busy_reg;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_lane[p].v) begin
                busy_next[wb_lane[p].ad] = 1'b0;
            end
        end
        if (push && entry_in.rd_v) begin
            busy_next[rd_ad] = 1'b1;
        end
        if (flush) begin
            busy_next = '0;
        end
        busy_next[0] = 1'b0;
    end

    // Busy scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    // Output FIFO: circular buffer with occupancy count; flush empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                queue_mem[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                queue_mem[wr_ptr_reg] <= entry_in;
                wr_ptr_reg <= PTR_W'(wrap_inc(32'(wr_ptr_reg), QDEPTH));
            end
            if (pop) begin
                rd_ptr_reg <= PTR_W'(wrap_inc(32'(rd_ptr_reg), QDEPTH));
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (!push && pop) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    // Saturating count of cycles where a valid instruction was held off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (in_v && !in_ready && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    // Head of queue drives the outputs directly; it stays put until popped.
    assign rs1_o     = queue_mem[rd_ptr_reg].rs1;
    assign rs2_o     = queue_mem[rd_ptr_reg].rs2;
    assign rd_o      = queue_mem[rd_ptr_reg].rd;
    assign rd_v_o    = queue_mem[rd_ptr_reg].rd_v;
    assign payload_o = queue_mem[rd_ptr_reg].payload;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_dispatch_scoreboard.sv
// Bench for dispatch_scoreboard: directed scenarios followed by random
// traffic, all checked against an instruction-level reference model.
module tb_dispatch_scoreboard;

    localparam int QD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_v;
    logic        in_ready;
    logic [4:0]  rs1_ad, rs2_ad, rd_ad;
    logic        rs1_use, rs2_use, rd_use;
    logic [95:0] payload_i;
    logic [1:0]  wb_v;
    logic [9:0]  wb_ad;
    logic [63:0] wb_data;
    logic        flush;
    logic        out_v;
    logic        out_ready;
    logic [31:0] rs1_o, rs2_o;
    logic [4:0]  rd_o;
    logic        rd_v_o;
    logic [95:0] payload_o;
    logic [31:0] stall_cnt;

    dispatch_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .in_v(in_v), .in_ready(in_ready),
        .rs1_ad(rs1_ad), .rs1_use(rs1_use), .rs2_ad(rs2_ad), .rs2_use(rs2_use),
        .rd_ad(rd_ad), .rd_use(rd_use), .payload_i(payload_i),
        .wb_v(wb_v), .wb_ad(wb_ad), .wb_data(wb_data), .flush(flush),
        .out_v(out_v), .out_ready(out_ready), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .rd_o(rd_o), .rd_v_o(rd_v_o), .payload_o(payload_o), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: architectural state and an instruction queue.
    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  rd;
        logic        rdv;
        logic [95:0] pl;
    } ent_t;

    logic [31:0] mregs [32];
    bit          mbusy [32];
    ent_t        mq [$];
    logic [31:0] mstall;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mregs[i] = '0;
            mbusy[i] = 1'b0;
        end
        mq.delete();
        mstall = '0;
    endtask

    function automatic bit m_written(input logic [4:0] a);
        for (int p = 0; p < 2; p++) begin
            if (wb_v[p] && wb_ad[p*5 +: 5] == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Register value as seen this cycle: latest writeback on the highest port wins.
    function automatic logic [31:0] m_read(input logic [4:0] a);
        logic [31:0] v;
        if (a == 0) return '0;
        v = mregs[a];
        for (int p = 0; p < 2; p++) begin
            if (wb_v[p] && wb_ad[p*5 +: 5] == a) v = wb_data[p*32 +: 32];
        end
        return v;
    endfunction

    function automatic bit m_src_ok(input bit use_it, input logic [4:0] a);
        return !use_it || a == 0 || !mbusy[a] || m_written(a);
    endfunction

    task automatic idle();
        in_v = 0; rs1_ad = 0; rs1_use = 0; rs2_ad = 0; rs2_use = 0;
        rd_ad = 0; rd_use = 0; payload_i = '0; wb_v = 0; wb_ad = '0;
        wb_data = '0; flush = 0; out_ready = 1;
    endtask

    task automatic set_inst(input logic [4:0] a1, input bit u1, input logic [4:0] a2,
                            input bit u2, input logic [4:0] d, input bit ud,
                            input logic [95:0] pl);
        in_v = 1; rs1_ad = a1; rs1_use = u1; rs2_ad = a2; rs2_use = u2;
        rd_ad = d; rd_use = ud; payload_i = pl;
    endtask

    task automatic set_wb(input int p, input logic [4:0] a, input logic [31:0] d);
        wb_v[p] = 1'b1;
        wb_ad[p*5 +: 5] = a;
        wb_data[p*32 +: 32] = d;
    endtask

    // One clock: check outputs against the model, then advance the model.
    task automatic cycle();
        bit   exp_ready;
        bit   space;
        ent_t e;
        #1;
        space = (mq.size() < QD) || (mq.size() > 0 && out_ready);
        exp_ready = !flush && m_src_ok(rs1_use, rs1_ad) && m_src_ok(rs2_use, rs2_ad)
                    && m_src_ok(rd_use, rd_ad) && space;
        chk("in_ready", in_ready, exp_ready);
        chk("out_v", out_v, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("rs1_o", rs1_o, mq[0].r1);
            chk("rs2_o", rs2_o, mq[0].r2);
            chk("rd_o", rd_o, mq[0].rd);
            chk("rd_v_o", rd_v_o, mq[0].rdv);
            chk("payload_o", payload_o, mq[0].pl);
        end
        chk("stall_cnt", stall_cnt, mstall);
        e.r1  = rs1_use ? m_read(rs1_ad) : '0;
        e.r2  = rs2_use ? m_read(rs2_ad) : '0;
        e.rd  = rd_ad;
        e.rdv = rd_use && rd_ad != 0;
        e.pl  = payload_i;
        @(posedge clk);
        if (mq.size() != 0 && out_ready) void'(mq.pop_front());
        if (in_v && exp_ready) mq.push_back(e);
        for (int p = 0; p < 2; p++) begin
            if (wb_v[p]) begin
                if (wb_ad[p*5 +: 5] != 0) mregs[wb_ad[p*5 +: 5]] = wb_data[p*32 +: 32];
                mbusy[wb_ad[p*5 +: 5]] = 1'b0;
            end
        end
        if (in_v && exp_ready && e.rdv) mbusy[e.rd] = 1'b1;
        if (flush) begin
            mq.delete();
            for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
        end
        if (in_v && !exp_ready && mstall != 32'hFFFF_FFFF) mstall = mstall + 1;
        @(negedge clk);
    endtask

    task automatic async_reset();
        #3 rst_n = 1'b0;
        #1;
        chk("areset_out_v", out_v, 1'b0);
        chk("areset_stall", stall_cnt, 32'd0);
        chk("areset_rs1_o", rs1_o, 32'd0);
        model_reset();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset values
        chk("rst_out_v", out_v, 1'b0);
        chk("rst_rs1_o", rs1_o, 32'd0);
        chk("rst_rs2_o", rs2_o, 32'd0);
        chk("rst_rd_o", rd_o, 5'd0);
        chk("rst_rd_v_o", rd_v_o, 1'b0);
        chk("rst_payload", payload_o, 96'd0);
        chk("rst_stall", stall_cnt, 32'd0);

        // First issue after reset reads zeros
        set_inst(5, 1, 6, 1, 0, 0, 96'hA0);
        cycle();
        idle();
        chk("first_out_v", out_v, 1'b1);
        chk("first_rs1", rs1_o, 32'd0);
        chk("first_rs2", rs2_o, 32'd0);
        cycle();

        // RAW stall resolved by a forwarded writeback
        set_inst(0, 0, 0, 0, 3, 1, 96'hA1);
        cycle();
        set_inst(3, 1, 0, 0, 0, 0, 96'hA2);
        repeat (3) cycle();
        set_wb(0, 3, 32'hDEAD);
        cycle();
        idle();
        chk("raw_fwd_rs1", rs1_o, 32'hDEAD);
        chk("raw_stall_cnt", stall_cnt, 32'd3);
        cycle();

        // Two ports writing the same register: port 1 wins
        set_inst(7, 1, 0, 0, 0, 0, 96'hA3);
        set_wb(0, 7, 32'h11);
        set_wb(1, 7, 32'h22);
        cycle();
        idle();
        chk("coll_fwd", rs1_o, 32'h22);
        cycle();
        set_inst(0, 0, 7, 1, 0, 0, 96'hA4);
        cycle();
        idle();
        chk("coll_reg", rs2_o, 32'h22);
        cycle();

        // Backpressure, push+pop when full, and pointer wrap
        idle();
        out_ready = 0;
        set_inst(1, 0, 2, 0, 0, 0, 96'hB0);
        cycle();
        set_inst(1, 0, 2, 0, 0, 0, 96'hB1);
        cycle();
        set_inst(1, 0, 2, 0, 0, 0, 96'hB2);
        #1 chk("bp_full_stall", in_ready, 1'b0);
        cycle();
        out_ready = 1;
        cycle();
        chk("bp_order_head", payload_o, 96'hB1);
        idle();
        repeat (3) cycle();

        // Flush clears queue and busy bits; flush-cycle writeback lands
        out_ready = 0;
        set_inst(0, 0, 0, 0, 4, 1, 96'hC0);
        cycle();
        set_inst(0, 0, 0, 0, 9, 1, 96'hC1);
        cycle();
        idle();
        flush = 1;
        set_wb(0, 12, 32'h55);
        cycle();
        idle();
        chk("flush_out_v", out_v, 1'b0);
        set_inst(4, 1, 9, 1, 0, 0, 96'hC2);
        #1 chk("flush_busy_clear", in_ready, 1'b1);
        cycle();
        set_inst(12, 1, 0, 0, 0, 0, 96'hC3);
        cycle();
        idle();
        chk("flush_wb_visible", rs1_o, 32'h55);
        cycle();

        // x0 rules
        set_inst(0, 1, 0, 1, 0, 1, 96'hD0);
        set_wb(1, 0, 32'h99);
        cycle();
        idle();
        chk("x0_rd_v", rd_v_o, 1'b0);
        chk("x0_rs1", rs1_o, 32'd0);
        set_inst(0, 1, 0, 0, 0, 1, 96'hD1);
        cycle();
        idle();
        chk("x0_rs1_after_wb", rs1_o, 32'd0);
        cycle();

        // Random traffic with one mid-stream asynchronous reset
        for (int n = 0; n < 800; n++) begin
            idle();
            if ($urandom_range(0, 9) < 7) begin
                set_inst(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                         5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                         5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                         {$urandom(), $urandom(), $urandom()});
            end
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 9) < 4) set_wb(p, 5'($urandom_range(0, 7)), $urandom());
            end
            flush = ($urandom_range(0, 24) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            if (n == 400) begin
                async_reset();
            end else begin
                cycle();
            end
        end

        idle();
        repeat (4) cycle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
